single_result_collector: RTL and testbench
==========================================

Name: single_result_collector

Overview:
- Downstream stage of the extended-single to single converter in the control-system datapath.
- Captures each 32-bit single result on the converter's done strobe into a small FIFO.
- Counts results per batch, flags overflow, and presents words to the control-system consumer over a valid/ready handshake.
- Decouples the fixed-latency converter, which cannot stall, from a consumer that may back-pressure.

Parameters:
- DATA_W, 32, word width; equals `SINGLE.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH).
- BATCH_LEN, 6, in_valid strobes per batch; range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- sta  input  1  batch start pulse; same strobe that launches the converter.
- in_valid  input  1  result strobe; driven by the converter's done_sig.
- in_data  input  DATA_W  single-precision result; driven by the converter's y.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  FIFO non-empty.
- out_data  output  DATA_W  head-of-FIFO word.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a word was dropped.
- batch_done  output  1  one-cycle pulse; BATCH_LEN strobes seen since sta.

Behaviour:
- Reset, rst low, asynchronous: pointers 0, count 0, out_valid 0, overflow 0, batch_done 0, batch counter 0. out_data is don't-care until the first push; the bench masks it while out_valid=0. Memory is not cleared.
- Reset mid-batch: FIFO contents and progress are discarded; the next accepted word lands at entry 0.
- FIFO is first-word-fall-through:
  - out_data = mem[rd_ptr].
  - out_valid = (count != 0).
- Push: in_valid=1 and (count<DEPTH or pop this cycle). Writes mem[wr_ptr], then wr_ptr+1 (wraps mod DEPTH).
- Pop: out_valid=1 and out_ready=1. rd_ptr+1 (wraps).
- Push-to-output latency: a word pushed at edge N appears on out_data/out_valid after edge N when the FIFO was empty.
- Count update: push only +1; pop only -1; both 0. Push and pop in the same cycle while full are both permitted.
- Full, in_valid=1, no pop: the word is dropped, overflow set at the next edge, count stays DEPTH.
- Empty with out_ready=1: no pop; pointers unchanged.
- Batch counter, 8 bits:
  - Increments on every in_valid, dropped words included.
  - When it reaches BATCH_LEN: batch_done pulses high for exactly one cycle, registered one edge after the strobe edge.
  - The counter then holds until the next sta; further strobes do not re-pulse.
- sta=1:
  - Batch counter cleared to 0 and overflow cleared.
  - FIFO contents preserved.
  - sta coincident with in_valid: the counter loads 1, and overflow may be set if that word is dropped, because set has priority over clear.
- No combinational path from in_* to out_*. out_ready affects only state.

Optional Feature:
- Macro: SINGLE_NAN_CHECK_EN.
- Defined:
  - Adds output nan_flag (1 bit, sticky). Set when a pushed word has exponent bits [30:23] = 8'hFF, i.e. NaN or Inf.
  - Cleared by sta and by reset; set has priority over clear.
  - Dropped words are not checked.
- Undefined: port absent, no checking logic.

Test Plan:
- Reset, then 3 in_valid strobes with 32'h3F800000, 32'h40000000, 32'h40400000, out_ready=1 -> out_data sequence identical, count returns to 0, overflow=0.
- out_ready=0, 9 strobes -> count=8, overflow=1 one edge after the 9th; on drain, words 1..8 in order and the 9th absent.
- Full FIFO, in_valid and out_ready both high for 4 cycles -> count stays 8, order preserved across pointer wrap, overflow unchanged.
- sta then 6 strobes at BATCH_LEN=6 -> batch_done high exactly one cycle after the 6th strobe edge; a 7th strobe produces no pulse; the next sta plus 6 strobes pulses again.
- rst low asynchronously with count=5 mid-batch -> all outputs zero immediately; next push appears as out_data with count=1.
- With SINGLE_NAN_CHECK_EN, push 32'h7FC00000 -> nan_flag=1, held until sta; push 32'h7F7FFFFF -> nan_flag stays 0.

Source files
------------

// File: rtl/single_result_collector.sv
// Result collector: FWFT FIFO behind the non-stallable converter, with batch counting and a sticky drop flag.
// Optional SINGLE_NAN_CHECK_EN adds a sticky nan_flag for pushed words whose exponent is all ones.
module single_result_collector #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int BATCH_LEN = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sta,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              batch_done
`ifdef SINGLE_NAN_CHECK_EN
  ,
  output logic              nan_flag
`endif
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]     BLEN_C  = 8'(BATCH_LEN);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic              batch_done_q, batch_done_d;
  logic              push, pop;

  always_comb begin
    pop  = (count_q != '0) && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push = in_valid && ((count_q != DEPTH_C) || pop);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (sta)
      overflow_d = 1'b0;
    if (in_valid && !push)
      overflow_d = 1'b1;

    // Counter saturates at BATCH_LEN so later strobes cannot re-pulse batch_done.
    bcnt_d = sta ? 8'd0 : bcnt_q;
    if (in_valid && (bcnt_d != BLEN_C))
      bcnt_d = bcnt_d + 8'd1;
    batch_done_d = in_valid && (bcnt_d == BLEN_C) && (sta || (bcnt_q != BLEN_C));
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      bcnt_q       <= 8'd0;
      batch_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      bcnt_q       <= bcnt_d;
      batch_done_q <= batch_done_d;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign batch_done = batch_done_q;

`ifdef SINGLE_NAN_CHECK_EN
  logic nan_q, nan_d;

  always_comb begin
    nan_d = sta ? 1'b0 : nan_q;
    if (push && (in_data[30:23] == 8'hFF))
      nan_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      nan_q <= 1'b0;
    else
      nan_q <= nan_d;
  end

  assign nan_flag = nan_q;
`endif

endmodule

// File: tb/tb_single_result_collector.sv
// Scoreboard bench for single_result_collector: directed scenarios followed by random traffic.
module tb_single_result_collector;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int BL     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sta = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [PTR_W:0]    count;
  logic              overflow;
  logic              batch_done;
`ifdef SINGLE_NAN_CHECK_EN
  logic              nan_flag;
`endif

  single_result_collector #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .BATCH_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .sta(sta), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .count(count), .overflow(overflow), .batch_done(batch_done)
`ifdef SINGLE_NAN_CHECK_EN
    , .nan_flag(nan_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 0;

  // Reference model: the queue is the FIFO; scalars are the architectural state.
  logic [31:0] exp_q[$];
  int exp_count = 0, nxt_count = 0, bcnt = 0;
  bit exp_ovf = 0, nxt_ovf = 0, exp_bd = 0, nxt_bd = 0, exp_nan = 0, nxt_nan = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit s, input bit iv, input logic [31:0] d, input bit rdy);
    bit p_pop, p_push;
    @(posedge clk);
    #1;
    exp_count = nxt_count; exp_ovf = nxt_ovf; exp_bd = nxt_bd; exp_nan = nxt_nan;
    sta = s; in_valid = iv; in_data = d; out_ready = rdy;
    p_pop  = (exp_count > 0) && rdy;
    p_push = iv && ((exp_count < DEPTH) || p_pop);
    if (p_push) exp_q.push_back(d);
    nxt_count = exp_count + int'(p_push) - int'(p_pop);
    if (s) begin
      nxt_ovf = 0; nxt_nan = 0; bcnt = 0;
    end
    if (iv && !p_push) nxt_ovf = 1;
    if (p_push && d[30:23] == 8'hFF) nxt_nan = 1;
    nxt_bd = 0;
    if (iv && bcnt < BL) begin
      bcnt++;
      nxt_bd = (bcnt == BL);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0; sta = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_batch_done", 32'(batch_done), 32'd0);
`ifdef SINGLE_NAN_CHECK_EN
    chk("rst_nan_flag", 32'(nan_flag), 32'd0);
`endif
    exp_q.delete();
    exp_count = 0; nxt_count = 0; bcnt = 0;
    exp_ovf = 0; nxt_ovf = 0; exp_bd = 0; nxt_bd = 0; exp_nan = 0; nxt_nan = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    armed = 1;
  endtask

  task automatic drain();
    repeat (DEPTH + 3) drive(0, 0, 32'd0, 1);
  endtask

  always @(negedge clk) begin
    if (armed && rst) begin
      chk("count", 32'(count), 32'(exp_count));
      chk("out_valid", 32'(out_valid), 32'(exp_count != 0));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("batch_done", 32'(batch_done), 32'(exp_bd));
`ifdef SINGLE_NAN_CHECK_EN
      chk("nan_flag", 32'(nan_flag), 32'(exp_nan));
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_data: DUT presents %h, required no word", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    do_reset();

    // Three words through an always-ready consumer.
    drive(0, 1, 32'h3F800000, 1);
    drive(0, 1, 32'h40000000, 1);
    drive(0, 1, 32'h40400000, 1);
    drain();

    // Nine words into a stalled FIFO: ninth dropped.
    for (int i = 1; i <= 9; i++) drive(0, 1, 32'(i), 0);
    drain();

    // Full FIFO with simultaneous push/pop across the pointer wrap.
    drive(1, 0, 32'd0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 32'h100 + 32'(i), 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h200 + 32'(i), 1);
    drain();

    // Batch pulses: sta + 6 strobes, 7th strobe silent, re-armed by sta.
    drive(1, 0, 32'd0, 1);
    for (int i = 0; i < 7; i++) drive(0, 1, 32'h300 + 32'(i), 1);
    drive(1, 0, 32'd0, 1);
    for (int i = 0; i < BL; i++) drive(0, 1, 32'h400 + 32'(i), 1);
    drive(1, 1, 32'h500, 1);
    drain();

    // Asynchronous reset mid-batch with five words held.
    drive(1, 0, 32'd0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 32'h600 + 32'(i), 0);
    do_reset();
    drive(0, 1, 32'hCAFE0001, 0);
    drive(0, 0, 32'd0, 0);
    drain();

    // Exponent-all-ones detection.
    drive(0, 1, 32'h7FC00000, 1);
    drive(0, 0, 32'd0, 1);
    drive(1, 0, 32'd0, 1);
    drive(0, 1, 32'h7F7FFFFF, 1);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      if ($urandom_range(7) == 0) d[30:23] = 8'hFF;
      drive($urandom_range(15) == 0, $urandom_range(1) == 1, d,
            $urandom_range(3) != 0 && (i % 64) < 40);
    end
    drain();
    drive(0, 0, 32'd0, 0);
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
